// File: rtl/e203_irq_inject_pkg.sv
// Shared types, constants and helpers for the E203 interrupt-injection scheduler.
package e203_irq_inject_pkg;

   typedef enum logic [1:0] {
      INJ_IDLE   = 2'd0,
      INJ_WAIT   = 2'd1,
      INJ_ASSERT = 2'd2,
      INJ_STOP   = 2'd3
   } inj_state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Each source sees the shared LFSR word through its own rotation
   localparam int unsigned ROT_EXT = 0;
   localparam int unsigned ROT_SFT = 5;
   localparam int unsigned ROT_TMR = 10;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned amt);
      logic [31:0] dbl;
      dbl = {v, v} << amt;
      return dbl[31:16];
   endfunction

endpackage

// File: rtl/e203_irq_inject_if.sv
// Commit bus from the core plus the three IRQ lines driven back into the subsystem.
interface e203_irq_inject_if #(
   parameter int unsigned PC_SIZE = 32
);
   logic               cmt_valid;
   logic [PC_SIZE-1:0] cmt_pc;
   logic               ext_irq_o;
   logic               sft_irq_o;
   logic               tmr_irq_o;

   modport master (
      output cmt_valid, cmt_pc,
      input  ext_irq_o, sft_irq_o, tmr_irq_o
   );

   modport slave (
      input  cmt_valid, cmt_pc,
      output ext_irq_o, sft_irq_o, tmr_irq_o
   );
endinterface

// File: rtl/e203_irq_inject_src.sv
// One injection source: sequencing FSM, delay down-counter and registered IRQ.
//
// state      | meaning
// INJ_IDLE   | disarmed; loads a fresh delay as soon as enable is seen
// INJ_WAIT   | counting the delay down; raises the IRQ when it reaches 1
// INJ_ASSERT | IRQ high until the handler-exit PC commits
// INJ_STOP   | tohost limit exceeded; parked until reset
module e203_irq_inject_src
   import e203_irq_inject_pkg::*;
#(
   parameter int unsigned DLY_W = 10,
   parameter int unsigned ROT   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        stop,
   input  logic        ack,
   input  logic [15:0] lfsr,
   output logic        irq,
   output logic        busy
);

   inj_state_e       state_q, state_nxt;
   logic [DLY_W-1:0] cnt_q, cnt_nxt;
   logic [DLY_W-1:0] dly_field, dly_load;
   logic             irq_d;

   assign dly_field = DLY_W'(rotl16(lfsr, ROT));
   assign dly_load  = (dly_field == '0) ? DLY_W'(1) : dly_field;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INJ_IDLE;
         cnt_q   <= '0;
         irq     <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         irq     <= irq_d;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         INJ_IDLE: begin
            if (enable) begin
               state_nxt = INJ_WAIT;
               cnt_nxt   = dly_load;
            end
         end
         INJ_WAIT: begin
            if (stop)                      state_nxt = INJ_STOP;
            else if (!enable)              state_nxt = INJ_IDLE;
            else if (cnt_q == DLY_W'(1))   state_nxt = INJ_ASSERT;
            else                           cnt_nxt   = cnt_q - DLY_W'(1);
         end
         // Only the ack can end an assertion; stop/enable are deferred to it
         INJ_ASSERT: begin
            if (ack) begin
               if (stop)         state_nxt = INJ_STOP;
               else if (!enable) state_nxt = INJ_IDLE;
               else begin
                  state_nxt = INJ_WAIT;
                  cnt_nxt   = dly_load;
               end
            end
         end
         INJ_STOP: state_nxt = INJ_STOP;
         default:  state_nxt = INJ_IDLE;
      endcase
   end

   always_comb begin
      irq_d = (state_nxt == INJ_ASSERT);
      busy  = (state_q == INJ_WAIT) || (state_q == INJ_ASSERT) ||
              ((state_q == INJ_IDLE) && enable);
   end

endmodule

// File: rtl/e203_irq_inject_ctrl.sv
// Interrupt-injection scheduler top: shared LFSR, cycle/tohost counters, stop and done.
module e203_irq_inject_ctrl
   import e203_irq_inject_pkg::*;
#(
   parameter int unsigned PC_SIZE   = 32,
   parameter int unsigned DLY_W     = 10,
   parameter int unsigned STOP_CNT  = 32,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   e203_irq_inject_if.slave   bus,
   input  logic [PC_SIZE-1:0] tohost_pc,
   input  logic [PC_SIZE-1:0] ext_ack_pc,
   input  logic [PC_SIZE-1:0] sft_ack_pc,
   input  logic [PC_SIZE-1:0] tmr_ack_pc,
   output logic [31:0]        tohost_cnt_o,
   output logic [31:0]        cycle_cnt_o,
   output logic [31:0]        first_tohost_cycle_o,
   output logic               done_o
);

   // An all-zero seed would lock the LFSR up
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [31:0] STOP_LIM = 32'(STOP_CNT);

   logic [15:0] lfsr_q;
   logic        stop;
   logic        tohost_hit;
   logic        ext_ack, sft_ack, tmr_ack;
   logic        ext_irq, sft_irq, tmr_irq;
   logic        ext_busy, sft_busy, tmr_busy;

   assign tohost_hit = bus.cmt_valid && (bus.cmt_pc == tohost_pc);
   assign ext_ack    = bus.cmt_valid && (bus.cmt_pc == ext_ack_pc);
   assign sft_ack    = bus.cmt_valid && (bus.cmt_pc == sft_ack_pc);
   assign tmr_ack    = bus.cmt_valid && (bus.cmt_pc == tmr_ack_pc);
   assign stop       = (tohost_cnt_o > STOP_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q               <= SEED_EFF;
         cycle_cnt_o          <= '0;
         tohost_cnt_o         <= '0;
         first_tohost_cycle_o <= '0;
      end else begin
         lfsr_q      <= lfsr_step(lfsr_q);
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
         if (tohost_hit) begin
            if (tohost_cnt_o == '0) first_tohost_cycle_o <= cycle_cnt_o;
            if (tohost_cnt_o != '1) tohost_cnt_o <= tohost_cnt_o + 32'd1;
         end
      end
   end

   e203_irq_inject_src #(.DLY_W(DLY_W), .ROT(ROT_EXT)) u_ext (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .stop   (stop),
      .ack    (ext_ack),
      .lfsr   (lfsr_q),
      .irq    (ext_irq),
      .busy   (ext_busy)
   );

   e203_irq_inject_src #(.DLY_W(DLY_W), .ROT(ROT_SFT)) u_sft (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .stop   (stop),
      .ack    (sft_ack),
      .lfsr   (lfsr_q),
      .irq    (sft_irq),
      .busy   (sft_busy)
   );

   e203_irq_inject_src #(.DLY_W(DLY_W), .ROT(ROT_TMR)) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .stop   (stop),
      .ack    (tmr_ack),
      .lfsr   (lfsr_q),
      .irq    (tmr_irq),
      .busy   (tmr_busy)
   );

   assign bus.ext_irq_o = ext_irq;
   assign bus.sft_irq_o = sft_irq;
   assign bus.tmr_irq_o = tmr_irq;

   assign done_o = stop && !(ext_busy || sft_busy || tmr_busy);

endmodule

// File: tb/tb_e203_irq_inject_ctrl.sv
// Directed bench for e203_irq_inject_ctrl with a cycle-level reference model and scoreboard.
module tb_e203_irq_inject_ctrl;

   localparam logic [31:0] EXT_PC = 32'h0000_0100;
   localparam logic [31:0] SFT_PC = 32'h0000_0200;
   localparam logic [31:0] TMR_PC = 32'h0000_0300;
   localparam logic [31:0] TOH_PC = 32'h0000_0400;
   localparam int ST_IDLE = 0, ST_WAIT = 1, ST_ASSERT = 2, ST_STOP = 3;

   typedef struct packed {
      logic [2:0]  irq;
      logic [31:0] toh;
      logic [31:0] cyc;
      logic [31:0] first;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [31:0] tohost_pc, ext_ack_pc, sft_ack_pc, tmr_ack_pc;
   logic [31:0] tohost_cnt, cycle_cnt, first_cyc;
   logic        done;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   int          m_st[3];
   int          m_cnt[3];
   logic [15:0] m_lfsr;
   logic [31:0] m_toh, m_cyc, m_first;

   always #5 clk = ~clk;

   e203_irq_inject_if #(.PC_SIZE(32)) bus ();

   e203_irq_inject_ctrl #(
      .PC_SIZE   (32),
      .DLY_W     (4),
      .STOP_CNT  (2),
      .LFSR_SEED (16'h0001)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .enable               (enable),
      .bus                  (bus),
      .tohost_pc            (tohost_pc),
      .ext_ack_pc           (ext_ack_pc),
      .sft_ack_pc           (sft_ack_pc),
      .tmr_ack_pc           (tmr_ack_pc),
      .tohost_cnt_o         (tohost_cnt),
      .cycle_cnt_o          (cycle_cnt),
      .first_tohost_cycle_o (first_cyc),
      .done_o               (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_st[i]  = ST_IDLE;
         m_cnt[i] = 0;
      end
      m_lfsr  = 16'h0001;
      m_toh   = '0;
      m_cyc   = '0;
      m_first = '0;
   endtask

   task automatic model_edge();
      logic        stop_now;
      logic [2:0]  ack;
      logic [31:0] dbl;
      logic [3:0]  ld;
      logic [15:0] l;
      if (!rst_n) begin
         model_reset();
         return;
      end
      stop_now = (m_toh > 32'd2);
      ack[0] = bus.cmt_valid && (bus.cmt_pc == EXT_PC);
      ack[1] = bus.cmt_valid && (bus.cmt_pc == SFT_PC);
      ack[2] = bus.cmt_valid && (bus.cmt_pc == TMR_PC);
      for (int i = 0; i < 3; i++) begin
         dbl = {m_lfsr, m_lfsr} << (5 * i);
         ld  = dbl[19:16];
         if (ld == 4'd0) ld = 4'd1;
         case (m_st[i])
            ST_IDLE: if (enable) begin m_st[i] = ST_WAIT; m_cnt[i] = int'(ld); end
            ST_WAIT: begin
               if (stop_now)          m_st[i] = ST_STOP;
               else if (!enable)      m_st[i] = ST_IDLE;
               else if (m_cnt[i] == 1) m_st[i] = ST_ASSERT;
               else                   m_cnt[i] = m_cnt[i] - 1;
            end
            ST_ASSERT: if (ack[i]) begin
               if (stop_now)     m_st[i] = ST_STOP;
               else if (!enable) m_st[i] = ST_IDLE;
               else begin m_st[i] = ST_WAIT; m_cnt[i] = int'(ld); end
            end
            default: ;
         endcase
      end
      if (bus.cmt_valid && (bus.cmt_pc == TOH_PC)) begin
         if (m_toh == 32'd0) m_first = m_cyc;
         if (m_toh != 32'hFFFF_FFFF) m_toh = m_toh + 32'd1;
      end
      m_cyc = m_cyc + 32'd1;
      l = m_lfsr >> 1;
      if (m_lfsr[0]) l = l ^ 16'hB400;
      m_lfsr = l;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic busy;
      busy = 1'b0;
      for (int i = 0; i < 3; i++)
         if (m_st[i] == ST_WAIT || m_st[i] == ST_ASSERT || (m_st[i] == ST_IDLE && enable))
            busy = 1'b1;
      e.irq   = {m_st[2] == ST_ASSERT, m_st[1] == ST_ASSERT, m_st[0] == ST_ASSERT};
      e.toh   = m_toh;
      e.cyc   = m_cyc;
      e.first = m_first;
      e.done  = (m_toh > 32'd2) && !busy;
      return e;
   endfunction

   // One clock: model advances at the edge, DUT is compared at the following negedge
   task automatic step();
      exp_t e;
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_out());
      @(negedge clk);
      e = exp_q.pop_front();
      chk("sb_irq", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, {29'd0, e.irq});
      chk("sb_tohost_cnt", tohost_cnt, e.toh);
      chk("sb_cycle_cnt", cycle_cnt, e.cyc);
      chk("sb_first_tohost", first_cyc, e.first);
      chk("sb_done", {31'd0, done}, {31'd0, e.done});
   endtask

   task automatic commit_step(input logic [31:0] pc);
      bus.cmt_valid = 1'b1;
      bus.cmt_pc    = pc;
      step();
      bus.cmt_valid = 1'b0;
      bus.cmt_pc    = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_n         = 1'b0;
      enable        = 1'b0;
      bus.cmt_valid = 1'b0;
      bus.cmt_pc    = '0;
      tohost_pc     = TOH_PC;
      ext_ack_pc    = EXT_PC;
      sft_ack_pc    = SFT_PC;
      tmr_ack_pc    = TMR_PC;
      model_reset();

      @(negedge clk);
      chk("rst_irq", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd0);
      chk("rst_cycle", cycle_cnt, 32'd0);
      chk("rst_tohost", tohost_cnt, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // Seed 1 gives every source a delay of 1: IRQs two edges after release
      rst_n  = 1'b1;
      enable = 1'b1;
      step();
      chk("irq_low_cycle1", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd0);
      step();
      chk("irq_rise_cycle2", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd7);

      commit_step(EXT_PC);
      chk("ext_ack_drop", {31'd0, bus.ext_irq_o}, 32'd0);
      chk("ext_ack_sft_tmr", {30'd0, bus.tmr_irq_o, bus.sft_irq_o}, 32'd3);

      // Dropping enable must not truncate the sft assertion
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("sft_held_no_enable", {31'd0, bus.sft_irq_o}, 32'd1);
      end
      commit_step(SFT_PC);
      chk("sft_drop_after_ack", {31'd0, bus.sft_irq_o}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("sft_idle_no_enable", {31'd0, bus.sft_irq_o}, 32'd0);
      end
      enable = 1'b1;
      found  = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (bus.sft_irq_o) found = 1'b1;
      end
      chk("sft_rearm_rise", {31'd0, found}, 32'd1);

      for (int k = 0; k < 200 && m_cyc != 32'd100; k++) step();
      chk("reach_cycle_100", cycle_cnt, 32'd100);
      commit_step(TOH_PC);
      chk("first_tohost_100", first_cyc, 32'd100);
      chk("tohost_cnt_1", tohost_cnt, 32'd1);
      for (int k = 0; k < 100 && m_cyc != 32'd150; k++) step();
      chk("reach_cycle_150", cycle_cnt, 32'd150);
      commit_step(TOH_PC);
      chk("first_tohost_held", first_cyc, 32'd100);
      chk("tohost_cnt_2", tohost_cnt, 32'd2);
      chk("not_stopped_at_2", {31'd0, done}, 32'd0);

      // Steer ext into WAIT (>=2 cycles left) while tmr is still asserted
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         if (m_st[0] == ST_WAIT && m_cnt[0] >= 2 && m_st[2] == ST_ASSERT) found = 1'b1;
         else if (m_st[0] == ST_ASSERT) commit_step(EXT_PC);
         else step();
      end
      chk("stop_setup", {30'd0, found, bus.ext_irq_o}, 32'd2);
      commit_step(TOH_PC);
      chk("tohost_cnt_3", tohost_cnt, 32'd3);
      for (int k = 0; k < 40; k++) begin
         if (m_st[1] == ST_ASSERT) commit_step(SFT_PC);
         else step();
         chk("ext_never_after_stop", {31'd0, bus.ext_irq_o}, 32'd0);
         chk("tmr_held_after_stop", {31'd0, bus.tmr_irq_o}, 32'd1);
      end
      chk("done_wait_tmr", {31'd0, done}, 32'd0);
      commit_step(TMR_PC);
      chk("tmr_drop_final", {31'd0, bus.tmr_irq_o}, 32'd0);
      chk("done_final", {31'd0, done}, 32'd1);
      chk("tohost_final", tohost_cnt, 32'd3);
      for (int k = 0; k < 5; k++) step();

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rerise_after_reset", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd7);

      // Asynchronous reset in the middle of an assertion
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_irq", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd0);
      chk("async_rst_cycle", cycle_cnt, 32'd0);
      chk("async_rst_tohost", tohost_cnt, 32'd0);
      chk("async_rst_first", first_cyc, 32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      step();
      chk("seed_restored_c1", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd0);
      step();
      chk("seed_restored_c2", {29'd0, bus.tmr_irq_o, bus.sft_irq_o, bus.ext_irq_o}, 32'd7);
      for (int k = 0; k < 10; k++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
